// File: rtl/ttl_pkg.sv
// Shared definitions for the sim_ttl chip models: the Johnson counter
// encodings and the decode/legality helpers used by the 74HC4017 model.
`timescale 1ns/1ps

package ttl_pkg;

   // Five-stage Johnson encodings for counts 0 through 9
   localparam logic [4:0] JC_0 = 5'b00000;
   localparam logic [4:0] JC_1 = 5'b00001;
   localparam logic [4:0] JC_2 = 5'b00011;
   localparam logic [4:0] JC_3 = 5'b00111;
   localparam logic [4:0] JC_4 = 5'b01111;
   localparam logic [4:0] JC_5 = 5'b11111;
   localparam logic [4:0] JC_6 = 5'b11110;
   localparam logic [4:0] JC_7 = 5'b11100;
   localparam logic [4:0] JC_8 = 5'b11000;
   localparam logic [4:0] JC_9 = 5'b10000;

   // One-hot decode of a Johnson state; illegal codes decode to all zeros
   function automatic logic [9:0] johnson_decode(input logic [4:0] s);
      logic [9:0] q;
      q = 10'b0;
      case (s)
         JC_0: q = 10'b00_0000_0001;
         JC_1: q = 10'b00_0000_0010;
         JC_2: q = 10'b00_0000_0100;
         JC_3: q = 10'b00_0000_1000;
         JC_4: q = 10'b00_0001_0000;
         JC_5: q = 10'b00_0010_0000;
         JC_6: q = 10'b00_0100_0000;
         JC_7: q = 10'b00_1000_0000;
         JC_8: q = 10'b01_0000_0000;
         JC_9: q = 10'b10_0000_0000;
         default: q = 10'b0;
      endcase
      return q;
   endfunction

   // True for the ten codes the counter can reach by normal counting
   function automatic logic johnson_legal(input logic [4:0] s);
      logic ok;
      ok = 1'b0;
      case (s)
         JC_0, JC_1, JC_2, JC_3, JC_4,
         JC_5, JC_6, JC_7, JC_8, JC_9: ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/johnson5_core.sv
// Five-bit Johnson state register with asynchronous reset, clock inhibit
// and recovery from the 22 unreachable codes.
`timescale 1ns/1ps

module johnson5_core
   import ttl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inhibit,
   output logic [4:0] s
);

   logic armed;

   // Tracks reset one update behind, so a reset release landing in the same
   // timestep as a clock edge still blocks that edge; the following edge counts
   always_ff @(posedge rst or negedge rst) begin
      armed <= ~rst;
   end

   // Advance one Johnson step per enabled edge, forcing illegal codes back to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s <= JC_0;
      end else if (!inhibit && armed) begin
         if (johnson_legal(s)) begin
            s <= {s[3:0], ~s[4]};
         end else begin
            s <= JC_0;
         end
      end
   end

endmodule

// File: rtl/ic74hc4017.sv
// Pin-accurate model of the 74HC4017 decade counter / one-hot decoder.
// Optional macro TTL_PROP_DELAY_EN routes all outputs through a transport
// delay of T_PD ns; without it the outputs follow the state with zero delay.
`timescale 1ns/1ps

module ic74hc4017
   import ttl_pkg::*;
#(
   parameter int T_PD = 0
) (
   input  logic port14,
   input  logic port15,
   input  logic port13,
   output logic port3,
   output logic port2,
   output logic port4,
   output logic port7,
   output logic port10,
   output logic port1,
   output logic port5,
   output logic port6,
   output logic port9,
   output logic port11,
   output logic port12,
   input  logic port8,
   input  logic port16
);

   logic [4:0]  s;
   logic [10:0] pins_now;
   logic [10:0] pins_out;
   logic        unused_pins;

   johnson5_core u_core (
      .clk     (port14),
      .rst     (port15),
      .inhibit (port13),
      .s       (s)
   );

   // Carry in the top bit, decoded Q9..Q0 below it
   always_comb begin
      pins_now = {~s[4], johnson_decode(s)};
   end

`ifdef TTL_PROP_DELAY_EN
   // Transport delay: every output change, including the reset response, lands T_PD ns later
   always @(pins_now) begin
      pins_out <= #(T_PD) pins_now;
   end
`else
   // Zero-delay outputs
   always_comb begin
      pins_out = pins_now;
   end
`endif

   // Power pins and the delay parameter carry no logic in this build
   assign unused_pins = ^{port8, port16, T_PD};

   assign port3  = pins_out[0];
   assign port2  = pins_out[1];
   assign port4  = pins_out[2];
   assign port7  = pins_out[3];
   assign port10 = pins_out[4];
   assign port1  = pins_out[5];
   assign port5  = pins_out[6];
   assign port6  = pins_out[7];
   assign port9  = pins_out[8];
   assign port11 = pins_out[9];
   assign port12 = pins_out[10];

endmodule

// File: tb/tb_ic74hc4017.sv
// Testbench for ic74hc4017: directed steps from the chip's behaviour list
// followed by a randomized run checked against a counter-modulo-10 model.
`timescale 1ns/1ps

module tb_ic74hc4017;

`ifdef TTL_PROP_DELAY_EN
   localparam int TPD = 10;
`else
   localparam int TPD = 0;
`endif
   localparam int SETTLE = TPD + 1;

   logic port14, port15, port13, port8, port16;
   logic port3, port2, port4, port7, port10, port1, port5, port6, port9, port11, port12;

   int total = 0;
   int bad = 0;
   int model_count = 0;

   ic74hc4017 #(.T_PD(TPD)) dut (
      .port14 (port14),
      .port15 (port15),
      .port13 (port13),
      .port3  (port3),
      .port2  (port2),
      .port4  (port4),
      .port7  (port7),
      .port10 (port10),
      .port1  (port1),
      .port5  (port5),
      .port6  (port6),
      .port9  (port9),
      .port11 (port11),
      .port12 (port12),
      .port8  (port8),
      .port16 (port16)
   );

   function automatic logic [9:0] onehot(input int k);
      logic [9:0] v;
      v = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   function automatic logic [9:0] observed_q();
      return {port11, port9, port6, port5, port1, port10, port7, port4, port2, port3};
   endfunction

   task automatic check_raw(input string tag, input logic [9:0] exp_q, input logic exp_co);
      logic [9:0] q;
      q = observed_q();
      total++;
      assert ({q, port12} === {exp_q, exp_co})
      else begin
         bad++;
         $error("FAIL %s: got q=%b co=%b, want q=%b co=%b", tag, q, port12, exp_q, exp_co);
      end
   endtask

   // Expected outputs follow directly from the decimal count held by the model
   task automatic check_output(input string tag);
      check_raw(tag, onehot(model_count), (model_count < 5) ? 1'b1 : 1'b0);
   endtask

   // One rising edge of port14 with the given inhibit level; leaves the clock high
   task automatic apply_stimulus(input logic inh);
      if (port14) begin
         port14 = 1'b0;
         #3;
      end
      port13 = inh;
      #2;
      port14 = 1'b1;
      if (!inh) model_count = (model_count + 1) % 10;
      #(SETTLE);
   endtask

   task automatic pulse_reset(input string tag);
      port15 = 1'b1;
      model_count = 0;
      #(SETTLE);
      check_output(tag);
      port15 = 1'b0;
      #3;
   endtask

   initial begin
      port14 = 1'b0;
      port15 = 1'b0;
      port13 = 1'b0;
      port8  = 1'b0;
      port16 = 1'b1;
      #5;

      $display("[TB] reset behaviour");
      port15 = 1'b1;
      model_count = 0;
      #(SETTLE);
      check_output("reset_asserted");
      port14 = 1'b1;
      #(SETTLE);
      check_output("edge_during_reset");
      port14 = 1'b0;
      #3;
      port15 = 1'b0;
      #(SETTLE);
      check_output("reset_released");

      $display("[TB] full cycle");
      for (int i = 1; i <= 12; i++) begin
         apply_stimulus(1'b0);
         check_output($sformatf("cycle_edge%0d", i));
      end

      $display("[TB] inhibit");
      apply_stimulus(1'b0);
      check_output("to_count3");
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1);
         check_output($sformatf("inhibit_hold%0d", i));
      end
      port14 = 1'b0;
      #3;
      port13 = 1'b0;
      #(SETTLE);
      check_output("inhibit_drop_no_edge");
      apply_stimulus(1'b0);
      check_output("after_inhibit");

      $display("[TB] async mid-count reset");
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0);
      check_output("at_count7");
      port14 = 1'b0;
      #2;
      port15 = 1'b1;
      model_count = 0;
      #(SETTLE);
      check_output("mid_count_reset");
      port14 = 1'b1;
      port15 = 1'b0;
      #(SETTLE);
      check_output("release_with_edge");
      apply_stimulus(1'b0);
      check_output("first_edge_after_release");

      $display("[TB] illegal state recovery");
      force dut.u_core.s = 5'b01010;
      #(SETTLE);
      check_raw("illegal_outputs", 10'b0, 1'b1);
      release dut.u_core.s;
      #1;
      apply_stimulus(1'b0);
      model_count = 0;
      check_output("illegal_recovery");

`ifdef TTL_PROP_DELAY_EN
      $display("[TB] propagation delay");
      pulse_reset("delay_reset");
      port14 = 1'b0;
      #3;
      port13 = 1'b0;
      port14 = 1'b1;
      #(TPD - 1);
      check_raw("before_tpd", onehot(0), 1'b1);
      #2;
      model_count = 1;
      check_output("after_tpd");
`endif

      $display("[TB] randomized run");
      for (int i = 0; i < 200; i++) begin
         int r;
         r = int'($urandom_range(0, 15));
         if (r == 0) begin
            pulse_reset($sformatf("rand_reset%0d", i));
         end else begin
            apply_stimulus((r % 3) == 0);
            check_output($sformatf("rand_step%0d", i));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
